tilt_move_gen: RTL

Produces the one-hot movement pulses that the ball-physics block consumes. It converts signed accelerometer tilt samples into a stream of single-cycle UP/DOWN/LEFT/RIGHT pulses. The pulse rate rises with tilt magnitude, and a mandatory idle gap follows each pulse so the ball can finish its map-collision scan before the next pulse. It sits between the accelerometer interface and the ball block.

---
 rtl/tilt_move_pkg.sv | 36 +++
 rtl/tilt_axis_timer.sv | 76 +++++++
 rtl/tilt_move_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tilt_move_pkg.sv
// Shared constants and helpers for the tilt-to-movement pulse generator.
// Direction encodings are also consumed by the ball-physics block.
package tilt_move_pkg;

    // One-hot movement directions
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    // Pulse FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Axis identifiers (used for selection and round-robin memory)
    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    // |t| with -128 saturated to 127 so the result always fits 7 bits
    function automatic logic [6:0] tilt_mag(input logic signed [7:0] t);
        logic [7:0] a;
        a = t[7] ? (~t + 8'd1) : t;
        return a[7] ? 7'd127 : a[6:0];
    endfunction

    // Speed level = (mag - deadzone) >> 5; a 7-bit difference tops out at 3.
    // Only meaningful when mag > dz.
    function automatic logic [1:0] tilt_level(input logic [6:0] mag, input logic [6:0] dz);
        logic [6:0] over;
        over = mag - dz;
        return over[6:5];
    endfunction

endpackage

// File: rtl/tilt_axis_timer.sv
// Per-axis tilt register and move-rate timer. Raises a sticky pending bit
// every PERIOD cycles while the axis is tilted past the deadzone.
module tilt_axis_timer import tilt_move_pkg::*; #(
    parameter int CNTR_WIDTH  = 32,
    parameter int BASE_CYCLES = 80,
    parameter int DEADZONE    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [7:0] sample_i,
    input  logic              valid_i,
    input  logic              enable_i,
    input  logic              clear_pending_i,
    output logic              pending_o,
    output logic              sign_o
);

    localparam logic [CNTR_WIDTH-1:0] BASE_W  = CNTR_WIDTH'(BASE_CYCLES);
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);
    localparam logic [6:0]            DZ      = 7'(DEADZONE);

    logic signed [7:0]     sample_q;
    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [6:0]            mag;
    logic [1:0]            level;
    logic [CNTR_WIDTH-1:0] period;
    logic                  active, wrap, flip;

    // Period follows the registered sample, so a new sample arriving on a
    // wrap cycle only changes the period from the following cycle.
    assign mag    = tilt_mag(sample_q);
    assign level  = tilt_level(mag, DZ);
    assign active = enable_i && (mag > DZ);
    assign period = BASE_W >> level;
    assign wrap   = (cnt_q == period - CNT_ONE);
    assign flip   = valid_i && (sample_i[7] != sample_q[7]);

    // Pending is masked as soon as the axis goes inactive so the FSM can
    // never launch a pulse for an axis that has just dropped out.
    assign pending_o = pend_q && active;
    assign sign_o    = sample_q[7];

    // Counter/pending next state; a wrap on the clear cycle keeps the move
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (!active) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (clear_pending_i) pend_d = 1'b0;
            if (wrap) begin
                cnt_d  = '0;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (flip) cnt_d = '0;
        end
    end

    // Sample capture and timer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            if (valid_i) sample_q <= sample_i;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/tilt_move_gen.sv
// Converts accelerometer tilt into single-cycle one-hot movement pulses,
// with a forced idle gap after each pulse for the ball collision scan.
module tilt_move_gen import tilt_move_pkg::*; #(
    parameter int CLK_FREQUENCY_HZ       = 100000000,
    parameter int UPDATE_FREQUENCY_HZ    = 30,
    parameter int SIMULATE               = 0,
    parameter int SIMULATE_FREQUENCY_CNT = 5,
    parameter int CNTR_WIDTH             = 32,
    parameter int DEADZONE               = 16,
    parameter int MIN_GAP_CYCLES         = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              tilt_valid,
    input  logic signed [7:0] tilt_x,
    input  logic signed [7:0] tilt_y,
    output logic [3:0]        movement,
    output logic              busy
);

    localparam int BASE_CYCLES = (SIMULATE != 0) ? 16 * SIMULATE_FREQUENCY_CNT
                                                 : CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ;
    localparam logic [CNTR_WIDTH-1:0] GAP_LAST = CNTR_WIDTH'(MIN_GAP_CYCLES - 1);
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic [3:0]            mov_q, mov_d;
    logic [CNTR_WIDTH-1:0] gap_q, gap_d;
    logic                  pend_x, pend_y, sign_x, sign_y;
    logic                  clr_x, clr_y;

    // Pending of the axis just pulsed is dropped while in PULSE
    assign clr_x = (state_q == ST_PULSE) && (sel_q == AXIS_X);
    assign clr_y = (state_q == ST_PULSE) && (sel_q == AXIS_Y);

    tilt_axis_timer #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .BASE_CYCLES(BASE_CYCLES),
        .DEADZONE   (DEADZONE)
    ) u_timer_x (
        .clk            (clk),
        .rst_n          (reset),
        .sample_i       (tilt_x),
        .valid_i        (tilt_valid),
        .enable_i       (enable),
        .clear_pending_i(clr_x),
        .pending_o      (pend_x),
        .sign_o         (sign_x)
    );

    tilt_axis_timer #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .BASE_CYCLES(BASE_CYCLES),
        .DEADZONE   (DEADZONE)
    ) u_timer_y (
        .clk            (clk),
        .rst_n          (reset),
        .sample_i       (tilt_y),
        .valid_i        (tilt_valid),
        .enable_i       (enable),
        .clear_pending_i(clr_y),
        .pending_o      (pend_y),
        .sign_o         (sign_y)
    );

    // FSM next state: arbitrate in IDLE, one-cycle PULSE, fixed-length GAP
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gap_d   = gap_q;
        mov_d   = DIR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (pend_x || pend_y) begin
                    // Both pending: alternate away from the last axis served
                    if (pend_x && pend_y) sel_d = ~last_q;
                    else                  sel_d = pend_x ? AXIS_X : AXIS_Y;
                    if (sel_d == AXIS_X) mov_d = sign_x ? DIR_LEFT : DIR_RIGHT;
                    else                 mov_d = sign_y ? DIR_UP   : DIR_DOWN;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                last_d  = sel_q;
                gap_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + CNT_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and registered movement output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= AXIS_Y;
            last_q  <= AXIS_Y;
            mov_q   <= DIR_NONE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            mov_q   <= mov_d;
            gap_q   <= gap_d;
        end
    end

    assign movement = mov_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
